// File: rtl/rvv_uop_sequencer_if.sv
// rvv_uop_sequencer_if: instruction-in / uop-out handshake bundle for the RVV uop sequencer
interface rvv_uop_sequencer_if #(parameter int REG_IDX_W = 5, parameter int UOP_IDX_W = 3);
  logic                 inst_valid;
  logic                 inst_ready;
  logic [2:0]           inst_lmul;
  logic                 inst_widen;
  logic                 inst_vs1_vec;
  logic [REG_IDX_W-1:0] inst_vd;
  logic [REG_IDX_W-1:0] inst_vs1;
  logic [REG_IDX_W-1:0] inst_vs2;
  logic                 uop_valid;
  logic                 uop_ready;
  logic [REG_IDX_W-1:0] uop_vd;
  logic [REG_IDX_W-1:0] uop_vs1;
  logic [REG_IDX_W-1:0] uop_vs2;
  logic [UOP_IDX_W-1:0] uop_index;
  logic                 uop_last;
  modport master (
    input  inst_valid, inst_lmul, inst_widen, inst_vs1_vec, inst_vd, inst_vs1, inst_vs2, uop_ready,
    output inst_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_index, uop_last
  );
  modport slave (
    output inst_valid, inst_lmul, inst_widen, inst_vs1_vec, inst_vd, inst_vs1, inst_vs2, uop_ready,
    input  inst_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_index, uop_last
  );
endinterface

// File: rtl/rvv_uop_sequencer.sv
// rvv_uop_sequencer: splits a decoded RVV ALU instruction into per-register-group uops
module rvv_uop_sequencer #(
  parameter int REG_IDX_W = 5,
  parameter int UOP_IDX_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  output logic illegal,
  output logic busy,
  rvv_uop_sequencer_if.master io
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_n;
  logic [REG_IDX_W-1:0] vd_r, vs1_r, vs2_r, off1, off2;
  logic [UOP_IDX_W-1:0] last_r, last_n, nxt;
  logic [2:0] k;
  logic widen_r, vec_r, ill, acc, hs;
  assign busy = state == ISSUE;
  assign io.uop_valid = busy;
  // k = log2(uop count); fractional LMUL always yields a single uop
  always_comb begin
    k = io.inst_lmul[2] ? 3'd0 : {1'b0, io.inst_lmul[1:0]} + {2'b0, io.inst_widen};
    ill = (io.inst_lmul[2] && !io.inst_lmul[1]) || (io.inst_widen && io.inst_lmul == 3'b011);
    last_n = UOP_IDX_W'((32'd1 << k) - 32'd1);
    io.inst_ready = !rst && !flush && (state == IDLE || (io.uop_valid && io.uop_ready && io.uop_last));
    acc = io.inst_valid && io.inst_ready;
    hs = io.uop_valid && io.uop_ready;
    nxt = io.uop_index + UOP_IDX_W'(1);
    off1 = REG_IDX_W'(nxt);
    off2 = widen_r ? off1 >> 1 : off1;
    state_n = flush ? IDLE : acc ? (ill ? IDLE : ISSUE) : (hs && io.uop_last) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal <= 1'b0;
      vd_r <= '0;
      vs1_r <= '0;
      vs2_r <= '0;
      widen_r <= 1'b0;
      vec_r <= 1'b0;
      last_r <= '0;
      io.uop_vd <= '0;
      io.uop_vs1 <= '0;
      io.uop_vs2 <= '0;
      io.uop_index <= '0;
      io.uop_last <= 1'b0;
    end else begin
      illegal <= acc && ill;
      if (acc && !ill) begin
        vd_r <= io.inst_vd;
        vs1_r <= io.inst_vs1;
        vs2_r <= io.inst_vs2;
        widen_r <= io.inst_widen;
        vec_r <= io.inst_vs1_vec;
        last_r <= last_n;
        io.uop_vd <= io.inst_vd;
        io.uop_vs1 <= io.inst_vs1;
        io.uop_vs2 <= io.inst_vs2;
        io.uop_index <= '0;
        io.uop_last <= last_n == '0;
      end else if (!flush && hs && !io.uop_last) begin
        io.uop_vd <= vd_r + off1;
        io.uop_vs2 <= vs2_r + off2;
        io.uop_vs1 <= vec_r ? vs1_r + off2 : vs1_r;
        io.uop_index <= nxt;
        io.uop_last <= nxt == last_r;
      end
    end
  end
endmodule

// File: tb/tb_rvv_uop_sequencer.sv
// tb_rvv_uop_sequencer: directed self-checking bench for rvv_uop_sequencer
module tb_rvv_uop_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic illegal, busy;
  int checks = 0;
  int failures = 0;
  rvv_uop_sequencer_if bus ();
  rvv_uop_sequencer dut (.clk(clk), .rst(rst), .flush(flush), .illegal(illegal), .busy(busy), .io(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_uop(input string tag, input logic [4:0] vd, input logic [4:0] vs2,
                         input logic [4:0] vs1, input logic [2:0] idx, input logic last);
    chk({tag, ".valid"}, 32'(bus.uop_valid), 32'd1);
    chk({tag, ".vd"}, 32'(bus.uop_vd), 32'(vd));
    chk({tag, ".vs2"}, 32'(bus.uop_vs2), 32'(vs2));
    chk({tag, ".vs1"}, 32'(bus.uop_vs1), 32'(vs1));
    chk({tag, ".index"}, 32'(bus.uop_index), 32'(idx));
    chk({tag, ".last"}, 32'(bus.uop_last), 32'(last));
  endtask
  task automatic drive(input logic [2:0] lmul, input logic widen, input logic vec,
                       input logic [4:0] vd, input logic [4:0] vs2, input logic [4:0] vs1);
    bus.inst_valid = 1'b1;
    bus.inst_lmul = lmul;
    bus.inst_widen = widen;
    bus.inst_vs1_vec = vec;
    bus.inst_vd = vd;
    bus.inst_vs2 = vs2;
    bus.inst_vs1 = vs1;
  endtask
  task automatic issue(input string tag, input logic [2:0] lmul, input logic widen, input logic vec,
                       input logic [4:0] vd, input logic [4:0] vs2, input logic [4:0] vs1);
    @(negedge clk);
    drive(lmul, widen, vec, vd, vs2, vs1);
    #1 chk({tag, ".inst_ready"}, 32'(bus.inst_ready), 32'd1);
    @(negedge clk);
    bus.inst_valid = 1'b0;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, ".uop_valid"}, 32'(bus.uop_valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    drive(3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    bus.inst_valid = 1'b0;
    bus.uop_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst.inst_ready", 32'(bus.inst_ready), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.vd", 32'(bus.uop_vd), 32'd0);
    chk("rst.vs1", 32'(bus.uop_vs1), 32'd0);
    chk("rst.vs2", 32'(bus.uop_vs2), 32'd0);
    chk("rst.index", 32'(bus.uop_index), 32'd0);
    chk("rst.last", 32'(bus.uop_last), 32'd0);
    rst = 1'b0;
    #1 chk("post_rst.inst_ready", 32'(bus.inst_ready), 32'd1);
    issue("lmul4", 3'b010, 1'b0, 1'b1, 5'd8, 5'd16, 5'd24);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk_uop("lmul4", 5'(8 + k), 5'(16 + k), 5'(24 + k), 3'(k), k == 3);
    end
    @(negedge clk);
    chk_idle("lmul4.end");
    issue("widen2", 3'b001, 1'b1, 1'b0, 5'd4, 5'd2, 5'd7);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk_uop("widen2", 5'(4 + k), 5'(2 + k / 2), 5'd7, 3'(k), k == 3);
    end
    @(negedge clk);
    chk_idle("widen2.end");
    issue("lmul8_stall", 3'b011, 1'b0, 1'b1, 5'd28, 5'd0, 5'd3);
    for (int k = 0; k < 8; k++) begin
      bus.uop_ready = 1'b0;
      #1 chk_uop("lmul8", 5'((28 + k) % 32), 5'(k), 5'(3 + k), 3'(k), k == 7);
      @(negedge clk);
      chk_uop("lmul8_stall", 5'((28 + k) % 32), 5'(k), 5'(3 + k), 3'(k), k == 7);
      bus.uop_ready = 1'b1;
      @(negedge clk);
    end
    chk_idle("lmul8.end");
    @(negedge clk);
    drive(3'b001, 1'b0, 1'b1, 5'd0, 5'd10, 5'd20);
    #1 chk("b2b.a_ready", 32'(bus.inst_ready), 32'd1);
    @(negedge clk);
    drive(3'b001, 1'b0, 1'b0, 5'd6, 5'd14, 5'd5);
    #1 chk("b2b.hold_ready", 32'(bus.inst_ready), 32'd0);
    chk_uop("b2b.a0", 5'd0, 5'd10, 5'd20, 3'd0, 1'b0);
    @(negedge clk);
    #1 chk("b2b.last_ready", 32'(bus.inst_ready), 32'd1);
    chk_uop("b2b.a1", 5'd1, 5'd11, 5'd21, 3'd1, 1'b1);
    @(negedge clk);
    bus.inst_valid = 1'b0;
    chk_uop("b2b.b0", 5'd6, 5'd14, 5'd5, 3'd0, 1'b0);
    @(negedge clk);
    chk_uop("b2b.b1", 5'd7, 5'd15, 5'd5, 3'd1, 1'b1);
    @(negedge clk);
    chk_idle("b2b.end");
    issue("ill_widen8", 3'b011, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    chk("ill_widen8.pulse", 32'(illegal), 32'd1);
    chk_idle("ill_widen8");
    @(negedge clk);
    chk("ill_widen8.drop", 32'(illegal), 32'd0);
    chk_idle("ill_widen8.after");
    issue("ill_rsv", 3'b100, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    chk("ill_rsv.pulse", 32'(illegal), 32'd1);
    chk_idle("ill_rsv");
    @(negedge clk);
    chk("ill_rsv.drop", 32'(illegal), 32'd0);
    chk_idle("ill_rsv.after");
    issue("flush", 3'b011, 1'b0, 1'b1, 5'd0, 5'd8, 5'd16);
    chk_uop("flush.u0", 5'd0, 5'd8, 5'd16, 3'd0, 1'b0);
    @(negedge clk);
    chk_uop("flush.u1", 5'd1, 5'd9, 5'd17, 3'd1, 1'b0);
    flush = 1'b1;
    drive(3'b000, 1'b0, 1'b1, 5'd9, 5'd9, 5'd9);
    #1 chk("flush.inst_ready", 32'(bus.inst_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.inst_valid = 1'b0;
    #1 chk_idle("flush.next");
    chk("flush.ready_after", 32'(bus.inst_ready), 32'd1);
    @(negedge clk);
    chk_idle("flush.not_accepted");
    issue("frac", 3'b111, 1'b0, 1'b1, 5'd31, 5'd31, 5'd31);
    chk_uop("frac", 5'd31, 5'd31, 5'd31, 3'd0, 1'b1);
    @(negedge clk);
    chk_idle("frac.end");
    issue("widen1", 3'b000, 1'b1, 1'b1, 5'd31, 5'd5, 5'd9);
    chk_uop("widen1.u0", 5'd31, 5'd5, 5'd9, 3'd0, 1'b0);
    @(negedge clk);
    chk_uop("widen1.u1", 5'd0, 5'd5, 5'd9, 3'd1, 1'b1);
    @(negedge clk);
    chk_idle("widen1.end");
    issue("rst_mid", 3'b010, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    chk_uop("rst_mid.u0", 5'd1, 5'd2, 5'd3, 3'd0, 1'b0);
    rst = 1'b1;
    #1 chk_idle("rst_mid.async");
    chk("rst_mid.inst_ready", 32'(bus.inst_ready), 32'd0);
    chk("rst_mid.vd", 32'(bus.uop_vd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_idle("rst_mid.release");
    @(negedge clk);
    chk_idle("rst_mid.after");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rvv_uop_sequencer.md
RVV_UOP_SEQUENCER -- requirements
Module: rvv_uop_sequencer

Interface
REQ-001 Parameter: REG_IDX_W, default 5, vector register index width (32 architectural registers).
REQ-002 Parameter: UOP_IDX_W, default 3, uop index width (maximum 8 uops per instruction).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous assertion, active-high.
REQ-005 Port: inst_valid  input  1  decoded ALU instruction offered.
REQ-006 Port: inst_ready  output  1  sequencer accepts the instruction this cycle.
REQ-007 Port: inst_lmul  input  3  vtype.vlmul encoding: 110=1/4, 111=1/2, 000=1, 001=2, 010=4, 011=8; 100=reserved.
REQ-008 Port: inst_widen  input  1  destination EMUL = 2×LMUL.
REQ-009 Port: inst_vs1_vec  input  1  1 = vs1 is a vector register group; 0 = scalar/imm, never incremented.
REQ-010 Port: inst_vd, inst_vs1, inst_vs2  input  REG_IDX_W each  base register indices.
REQ-011 Port: uop_valid  output  1  uop presented.
REQ-012 Port: uop_ready  input  1  downstream accepts the uop.
REQ-013 Port: uop_vd, uop_vs1, uop_vs2  output  REG_IDX_W each  per-uop register indices.
REQ-014 Port: uop_index  output  UOP_IDX_W  position of the uop within the instruction, starting at 0.
REQ-015 Port: uop_last  output  1  final uop of the instruction.
REQ-016 Port: flush  input  1  synchronous kill of the in-flight instruction.
REQ-017 Port: illegal  output  1  one-cycle pulse on rejecting an instruction.
REQ-018 Port: busy  output  1  high in ISSUE state.

Function
REQ-019 The FSM has exactly two states: IDLE and ISSUE.
REQ-020 Handshakes complete only when valid and ready are both high on the same rising edge.
REQ-021 Uop count N, non-widening: 1 for LMUL 1/4, 1/2 and 1; otherwise 2, 4 or 8.
REQ-022 Uop count N, widening: 1 for LMUL 1/4 and 1/2; 2, 4 or 8 for LMUL 1, 2 and 4.
REQ-023 Illegal instructions are reserved LMUL or widening with LMUL 8; they are accepted, emit zero uops, leave the FSM in IDLE and pulse illegal in the following cycle.
REQ-024 Uop i, non-widening: uop_vd=vd+i; uop_vs2=vs2+i; uop_vs1=vs1+i if inst_vs1_vec, else vs1.
REQ-025 Uop i, widening: uop_vd=vd+i; uop_vs2=vs2+(i>>1); uop_vs1=vs1+(i>>1) if inst_vs1_vec, else vs1.
REQ-026 All index additions are modulo 2^REG_IDX_W (31+1 wraps to 0).
REQ-027 uop_index=i; uop_last=1 exactly when i=N-1.
REQ-028 inst_ready = !flush && (state==IDLE || (uop_valid && uop_ready && uop_last)), allowing back-to-back instructions without a bubble.
REQ-029 A legal accept in cycle T drives uop_valid high in cycle T+1 with i=0 and moves the FSM to ISSUE.
REQ-030 In ISSUE, each uop handshake advances i by 1.
REQ-031 The handshake on the last uop returns the FSM to IDLE, unless a new instruction is accepted in the same cycle, in which case the FSM stays in ISSUE with i=0 for the new instruction.
REQ-032 While uop_valid=1 and uop_ready=0, all uop_* outputs hold stable.
REQ-033 uop_valid never deasserts without a handshake, except on flush or reset.
REQ-034 All uop_* outputs are registered; no combinational path exists from inst_* to uop_*.
REQ-035 flush has highest priority: the next cycle is IDLE with uop_valid=0, the remaining uops are dropped, and any instruction offered during flush is not accepted.
REQ-036 A uop handshake coincident with flush is consumed by downstream, and the sequencer discards all remaining state.
REQ-037 When uop_valid=0, uop_* data values are don't-care but must not be X after reset.

Reset
REQ-038 While rst=1: FSM=IDLE, uop_valid=0, illegal=0, busy=0, i=0, and all uop_* data registers =0.
REQ-039 inst_ready is low while rst=1 and equals 1 in the first cycle after rst deasserts, provided flush=0.
REQ-040 Reset asserted mid-instruction abandons it immediately, with no further uops after deassertion.

Verification
REQ-041 LMUL=4, vd=8, vs2=16, vs1=24 vec, uop_ready=1 -> 4 consecutive uops: vd 8..11, vs2 16..19, vs1 24..27, index 0..3, last only on index 3.
REQ-042 Widen, LMUL=2, vd=4, vs2=2, vs1 scalar=7 -> 4 uops: vd 4,5,6,7; vs2 2,2,3,3; vs1 7 on all; last on the 4th.
REQ-043 LMUL=8, vd=28, uop_ready toggling 1/0 -> vd sequence 28,29,30,31,0,1,2,3, with outputs stable during every stall.
REQ-044 Two back-to-back LMUL=2 instructions, uop_ready=1 -> 4 uops in 4 consecutive cycles, inst_ready high on the cycle of the first instruction's last uop.
REQ-045 Widen with LMUL=8, then reserved LMUL=100 -> each accepted, illegal pulses one cycle, no uop_valid.
REQ-046 flush on the second uop of an LMUL=8 instruction -> uop_valid=0 the next cycle, FSM IDLE, inst_ready=1 the cycle after flush drops.
